// File: rtl/relu_grad_gate_if.sv
// Handshake bundle for relu_grad_gate: forward mask channel, incoming gradient
// channel and outgoing gated-gradient channel. The slave modport is the gate
// itself; the master modport is whoever feeds it and drains its output.
interface relu_grad_gate_if #(
    parameter int DATA_W = 24,
    parameter int GRAD_W = 24
);
    // Forward channel: one pre-activation sample per accepted beat
    logic              fwd_valid;
    logic              fwd_ready;
    logic [DATA_W-1:0] fwd_in;

    // Incoming gradient channel
    logic              grad_in_valid;
    logic              grad_in_ready;
    logic [GRAD_W-1:0] grad_in;

    // Outgoing gated gradient channel
    logic              grad_out_valid;
    logic              grad_out_ready;
    logic [GRAD_W-1:0] grad_out;

    modport master (
        output fwd_valid,
        output fwd_in,
        input  fwd_ready,
        output grad_in_valid,
        output grad_in,
        input  grad_in_ready,
        input  grad_out_valid,
        input  grad_out,
        output grad_out_ready
    );

    modport slave (
        input  fwd_valid,
        input  fwd_in,
        output fwd_ready,
        input  grad_in_valid,
        input  grad_in,
        output grad_in_ready,
        output grad_out_valid,
        output grad_out,
        input  grad_out_ready
    );
endinterface

// File: rtl/relu_grad_gate.sv
// relu_grad_gate: backward companion of the forward rectifier.
// During the forward pass it records one mask bit per activation (1 = the
// rectifier passed it, i.e. the sample was non-negative) in a FIFO. During the
// backward pass it pops one mask bit per gradient and forwards either the
// gradient or a blocked value through a single output register.
//
// Build option: define RELU_LEAKY_GRAD_EN to turn blocked gradients into
// grad_in >>> LEAK_SHIFT instead of zero. Without it, blocked gradients are 0.
module relu_grad_gate #(
    parameter int DATA_W     = 24,
    parameter int GRAD_W     = 24,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_flush,
    relu_grad_gate_if.slave         bus,
    output logic [ADDR_W:0]         o_mask_count,
    output logic                    o_overflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    // Elaboration-time sanity checks on the configuration
    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("relu_grad_gate: DEPTH must equal 2**ADDR_W");
    end
    if (LEAK_SHIFT < 0 || LEAK_SHIFT >= GRAD_W) begin : g_bad_leak
        $error("relu_grad_gate: LEAK_SHIFT must lie in 0..GRAD_W-1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              r_mask_mem [0:DEPTH-1];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_out_valid;
    logic [GRAD_W-1:0] r_out_data;

    // ------------------------------------------------------------------
    // Combinational handshake and datapath
    // ------------------------------------------------------------------
    logic              w_full;
    logic              w_empty;
    logic              w_fwd_ready;
    logic              w_grad_in_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_new_mask;
    logic              w_rd_mask;
    logic [GRAD_W-1:0] w_blocked;
    logic [GRAD_W-1:0] w_gated;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    // No pass-through when full: readiness depends only on stored count.
    assign w_fwd_ready = !w_full;

    // A pop needs a stored mask and room in the output register. A push in the
    // same cycle as an empty FIFO is not visible until the next cycle.
    assign w_grad_in_ready = !w_empty && (!r_out_valid || bus.grad_out_ready);

    assign w_push = bus.fwd_valid && w_fwd_ready;
    assign w_pop  = bus.grad_in_valid && w_grad_in_ready;
    assign w_drop = bus.fwd_valid && !w_fwd_ready;

    // Zero counts as non-negative and is passed by the forward stage.
    assign w_new_mask = ~bus.fwd_in[DATA_W-1];
    assign w_rd_mask  = r_mask_mem[r_rd_ptr];

`ifdef RELU_LEAKY_GRAD_EN
    // Arithmetic shift keeps the sign and rounds toward minus infinity.
    assign w_blocked = $signed(bus.grad_in) >>> LEAK_SHIFT;
`else
    assign w_blocked = '0;
`endif

    // Select the gated gradient for the output register
    always_comb begin
        // NOTE: every output of an always_comb gets a value on every path; the
        // default first keeps the block free of inferred latches.
        w_gated = w_blocked;
        if (w_rd_mask) begin
            w_gated = bus.grad_in;
        end
    end

    // ------------------------------------------------------------------
    // Mask storage
    // ------------------------------------------------------------------

    // Write the mask of each accepted forward sample at the write pointer
    always_ff @(posedge clock) begin
        // NOTE: the mask array has no reset; its contents only matter once
        // r_count says an entry is valid, and that count is reset.
        if (w_push && !i_flush) begin
            r_mask_mem[r_wr_ptr] <= w_new_mask;
        end
    end

    // Advance the write pointer on every accepted push; flush rewinds it
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state is assigned with <= so every register in the
        // design samples the pre-edge values, independent of statement order.
        if (!reset) begin
            r_wr_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    // Advance the read pointer on every accepted gradient; flush rewinds it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Track occupancy; a simultaneous push and pop leaves it unchanged
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky record of a forward sample that arrived while the FIFO was full
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------

    // Output valid: set by a pop, held under backpressure, cleared once taken
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
        end else if (bus.grad_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Output data: loaded on a pop, otherwise holds (flush keeps the last value)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_data <= '0;
        end else if (!i_flush && w_pop) begin
            r_out_data <= w_gated;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.fwd_ready      = w_fwd_ready;
    assign bus.grad_in_ready  = w_grad_in_ready;
    assign bus.grad_out_valid = r_out_valid;
    assign bus.grad_out       = r_out_data;
    assign o_mask_count       = r_count;
    assign o_overflow         = r_overflow;

`ifndef SYNTHESIS
    // Occupancy never exceeds the depth and always matches the pointer distance
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (r_count <= FULL_COUNT);
            assert ((r_wr_ptr - r_rd_ptr) == r_count[ADDR_W-1:0]);
        end
    end
`endif

endmodule

// File: tb/tb_relu_grad_gate.sv
// Directed self-checking bench for relu_grad_gate. Expected values are written
// out by hand for both builds (RELU_LEAKY_GRAD_EN defined or not).
module tb_relu_grad_gate;

    localparam int DATA_W = 24;
    localparam int GRAD_W = 24;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic            clock   = 1'b0;
    logic            reset   = 1'b0;
    logic            i_flush = 1'b0;
    logic [ADDR_W:0] o_mask_count;
    logic            o_overflow;

    int n_checks   = 0;
    int n_failures = 0;

    relu_grad_gate_if #(.DATA_W(DATA_W), .GRAD_W(GRAD_W)) u_if ();

    relu_grad_gate #(
        .DATA_W    (DATA_W),
        .GRAD_W    (GRAD_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .LEAK_SHIFT(3)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .i_flush     (i_flush),
        .bus         (u_if.slave),
        .o_mask_count(o_mask_count),
        .o_overflow  (o_overflow)
    );

    always #5 clock = ~clock;

    // Count one comparison and report it if the observed value is wrong
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int gout();
        return int'($signed(u_if.grad_out));
    endfunction

    // Blocked value of a gradient in the current build
    function automatic int blocked(input int g);
`ifdef RELU_LEAKY_GRAD_EN
        return g >>> 3;
`else
        return 0;
`endif
    endfunction

    // Forward sample pattern for the streaming test: every third one negative
    function automatic int s4(input int k);
        return (k % 3 == 1) ? -(k + 1) : k;
    endfunction

    function automatic int g4(input int k);
        return 7 * k - 500;
    endfunction

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t1_fwd [4];
        int t1_grad[4];
        int t1_exp [4];
        int t3_fwd [8];
        int t3_exp [8];
        int t6_exp [2];

        t1_fwd  = '{5, -3, 0, -1};
        t1_grad = '{100, 100, -7, 42};
`ifdef RELU_LEAKY_GRAD_EN
        t1_exp  = '{100, 12, -7, 5};
        t6_exp  = '{-10, 2};
`else
        t1_exp  = '{100, 0, -7, 0};
        t6_exp  = '{0, 0};
`endif

        u_if.fwd_valid      = 1'b0;
        u_if.fwd_in         = '0;
        u_if.grad_in_valid  = 1'b0;
        u_if.grad_in        = '0;
        u_if.grad_out_ready = 1'b1;

        // ---------------- reset state ----------------
        @(negedge clock);
        check("rst_count",    int'(o_mask_count), 0);
        check("rst_valid",    int'(u_if.grad_out_valid), 0);
        check("rst_data",     gout(), 0);
        check("rst_overflow", int'(o_overflow), 0);
        check("rst_fwd_rdy",  int'(u_if.fwd_ready), 1);
        check("rst_grad_rdy", int'(u_if.grad_in_ready), 0);
        reset = 1'b1;

        // ---------------- test 1: basic gating ----------------
        for (int i = 0; i < 4; i++) begin
            u_if.fwd_valid = 1'b1;
            u_if.fwd_in    = DATA_W'(t1_fwd[i]);
            @(negedge clock);
        end
        u_if.fwd_valid = 1'b0;
        check("t1_count4", int'(o_mask_count), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_gin_rdy", int'(u_if.grad_in_ready), 1);
            u_if.grad_in_valid = 1'b1;
            u_if.grad_in       = GRAD_W'(t1_grad[i]);
            @(negedge clock);
            check("t1_valid", int'(u_if.grad_out_valid), 1);
            check($sformatf("t1_out%0d", i), gout(), t1_exp[i]);
        end
        u_if.grad_in_valid = 1'b0;
        @(negedge clock);
        check("t1_valid_clr", int'(u_if.grad_out_valid), 0);
        check("t1_count0",    int'(o_mask_count), 0);

        // ---------------- test 2: full, overflow, drain ----------------
        for (int i = 0; i < DEPTH; i++) begin
            u_if.fwd_valid = 1'b1;
            u_if.fwd_in    = DATA_W'(i + 1);
            @(negedge clock);
        end
        check("t2_count64",   int'(o_mask_count), 64);
        check("t2_fwd_rdy",   int'(u_if.fwd_ready), 0);
        check("t2_ovf_pre",   int'(o_overflow), 0);
        u_if.fwd_in = DATA_W'(1000);
        @(negedge clock);
        u_if.fwd_valid = 1'b0;
        check("t2_ovf_set",   int'(o_overflow), 1);
        check("t2_count_hold", int'(o_mask_count), 64);
        for (int i = 0; i < DEPTH; i++) begin
            u_if.grad_in_valid = 1'b1;
            u_if.grad_in       = GRAD_W'(i * 1000 - 20000);
            @(negedge clock);
            check($sformatf("t2_out%0d", i), gout(), i * 1000 - 20000);
        end
        u_if.grad_in_valid = 1'b0;
        @(negedge clock);
        check("t2_count0",   int'(o_mask_count), 0);
        check("t2_gin_rdy0", int'(u_if.grad_in_ready), 0);

        // ---------------- test 3: backpressure ----------------
        t3_fwd = '{1, -2, 3, -4, 5, -6, 7, -8};
        for (int k = 0; k < 8; k++) begin
            t3_exp[k] = (k % 2 == 0) ? (10 * k + 3) : blocked(10 * k + 3);
            u_if.fwd_valid = 1'b1;
            u_if.fwd_in    = DATA_W'(t3_fwd[k]);
            @(negedge clock);
        end
        u_if.fwd_valid     = 1'b0;
        u_if.grad_in_valid = 1'b1;
        u_if.grad_in       = GRAD_W'(3);
        @(negedge clock);
        check("t3_first", gout(), t3_exp[0]);
        u_if.grad_out_ready = 1'b0;
        u_if.grad_in        = GRAD_W'(13);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("t3_hold_valid", int'(u_if.grad_out_valid), 1);
            check("t3_hold_data",  gout(), t3_exp[0]);
            check("t3_hold_gin",   int'(u_if.grad_in_ready), 0);
            check("t3_hold_count", int'(o_mask_count), 7);
        end
        u_if.grad_out_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            @(negedge clock);
            check($sformatf("t3_out%0d", k), gout(), t3_exp[k]);
            if (k < 7) begin
                u_if.grad_in = GRAD_W'(10 * (k + 1) + 3);
            end else begin
                u_if.grad_in_valid = 1'b0;
            end
        end
        @(negedge clock);
        check("t3_valid_clr", int'(u_if.grad_out_valid), 0);
        check("t3_count0",    int'(o_mask_count), 0);

        // ---------------- test 4: streaming with count=1 ----------------
        u_if.fwd_valid = 1'b1;
        u_if.fwd_in    = DATA_W'(s4(0));
        @(negedge clock);
        u_if.grad_in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            u_if.fwd_in  = DATA_W'(s4(k + 1));
            u_if.grad_in = GRAD_W'(g4(k));
            @(negedge clock);
            check($sformatf("t4_out%0d", k), gout(),
                  (s4(k) >= 0) ? g4(k) : blocked(g4(k)));
            check("t4_count1", int'(o_mask_count), 1);
        end
        u_if.fwd_valid     = 1'b0;
        u_if.grad_in_valid = 1'b0;
        @(negedge clock);

        // ---------------- test 5: flush ----------------
        for (int k = 0; k < 10; k++) begin
            u_if.fwd_valid = 1'b1;
            u_if.fwd_in    = DATA_W'(-(k + 1));
            @(negedge clock);
        end
        u_if.fwd_valid      = 1'b0;
        u_if.grad_out_ready = 1'b0;
        u_if.grad_in_valid  = 1'b1;
        u_if.grad_in        = GRAD_W'(77);
        @(negedge clock);
        u_if.grad_in_valid = 1'b0;
        check("t5_pre_count", int'(o_mask_count), 10);
        check("t5_pre_valid", int'(u_if.grad_out_valid), 1);
        check("t5_pre_ovf",   int'(o_overflow), 1);
        check("t5_pre_data",  gout(), 77);
        i_flush = 1'b1;
        @(negedge clock);
        i_flush = 1'b0;
        check("t5_count",   int'(o_mask_count), 0);
        check("t5_valid",   int'(u_if.grad_out_valid), 0);
        check("t5_ovf",     int'(o_overflow), 0);
        check("t5_fwd_rdy", int'(u_if.fwd_ready), 1);
        check("t5_data",    gout(), 77);
        u_if.grad_out_ready = 1'b1;

        // ---------------- test 6: blocked value per build ----------------
        for (int k = 0; k < 2; k++) begin
            u_if.fwd_valid = 1'b1;
            u_if.fwd_in    = DATA_W'(-5);
            @(negedge clock);
        end
        u_if.fwd_valid     = 1'b0;
        u_if.grad_in_valid = 1'b1;
        u_if.grad_in       = GRAD_W'(-80);
        @(negedge clock);
        check("t6_neg80", gout(), t6_exp[0]);
        u_if.grad_in = GRAD_W'(17);
        @(negedge clock);
        check("t6_pos17", gout(), t6_exp[1]);
        u_if.grad_in_valid = 1'b0;
        @(negedge clock);

        // ---------------- test 7: asynchronous reset mid-operation ----------------
        for (int k = 0; k < 3; k++) begin
            u_if.fwd_valid = 1'b1;
            u_if.fwd_in    = DATA_W'(k + 1);
            @(negedge clock);
        end
        u_if.fwd_valid      = 1'b0;
        u_if.grad_out_ready = 1'b0;
        u_if.grad_in_valid  = 1'b1;
        u_if.grad_in        = GRAD_W'(55);
        @(negedge clock);
        u_if.grad_in_valid = 1'b0;
        check("t7_pre_data", gout(), 55);
        #2;
        reset = 1'b0;
        #1;
        check("t7_count", int'(o_mask_count), 0);
        check("t7_valid", int'(u_if.grad_out_valid), 0);
        check("t7_data",  gout(), 0);
        check("t7_fwd_rdy", int'(u_if.fwd_ready), 1);
        @(negedge clock);
        reset               = 1'b1;
        u_if.grad_out_ready = 1'b1;
        u_if.fwd_valid      = 1'b1;
        u_if.fwd_in         = DATA_W'(-9);
        @(negedge clock);
        u_if.fwd_in = DATA_W'(4);
        @(negedge clock);
        u_if.fwd_valid = 1'b0;
        check("t7_refill", int'(o_mask_count), 2);
        u_if.grad_in_valid = 1'b1;
        u_if.grad_in       = GRAD_W'(30);
        @(negedge clock);
        check("t7_out0", gout(), blocked(30));
        u_if.grad_in = GRAD_W'(31);
        @(negedge clock);
        check("t7_out1", gout(), 31);
        u_if.grad_in_valid = 1'b0;
        @(negedge clock);
        check("t7_count0", int'(o_mask_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
